// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage for the LEGv8 datapath. Owns the 64-bit PC, reads
// four bytes (little-endian) from a byte-wide synchronous instruction memory
// with one cycle of read latency, and presents the assembled 32-bit
// instruction and its PC to decode over a valid/ready handshake. Decode
// returns the next-PC redirect (PCSrc / BranchAddress) with the handshake.
//
// Optional feature: define FETCH_HALT_DETECT_EN to enable HALT detection
// (instruction[31:21] == 11'h7FF). The HALT is still presented to decode;
// its handshake parks the unit in HALTED until reset. Undefined, 11'h7FF is
// an ordinary instruction and `halted` is constant 0.
//
// Parameters:
//   PC_RESET       PC value loaded on reset
//   ADDR_W         instruction-memory byte-address width
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   imem_addr      byte address to instruction memory (0 when not reading)
//   imem_rd        read strobe; data returns the following cycle
//   imem_data      byte from memory, valid one cycle after imem_rd
//   instruction    assembled instruction
//   PC             byte address of the held instruction
//   inst_valid     instruction / PC valid for decode
//   inst_ready     decode accepts the current instruction
//   PCSrc          redirect select for the instruction being accepted
//   BranchAddress  redirect target (bits [1:0] ignored)
//   halted         HALT accepted; fetch stopped
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [7:0]        imem_data,
    output logic [31:0]       instruction,
    output logic [63:0]       PC,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              PCSrc,
    input  logic [63:0]       BranchAddress,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_FETCH  = 2'd1,
        S_VALID  = 2'd2
`ifdef FETCH_HALT_DETECT_EN
        , S_HALTED = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [63:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;

    // NOTE: the reset branch is asynchronous, so a reset mid-FETCH discards
    // partially assembled bytes immediately; all state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
            cnt_q   <= '0;
            pc_q    <= PC_RESET;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imem_rd    = 1'b0;
        imem_addr  = '0;
        inst_valid = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end

            S_FETCH: begin
                // Issue cycles cnt=0..3; the byte address wraps within memory.
                if (cnt_q <= 3'd3) begin
                    imem_rd   = 1'b1;
                    imem_addr = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
                end
                // Capture cycles cnt=1..4 take the byte requested one cycle ago.
                case (cnt_q)
                    3'd1:    instr_d[7:0]   = imem_data;
                    3'd2:    instr_d[15:8]  = imem_data;
                    3'd3:    instr_d[23:16] = imem_data;
                    3'd4:    instr_d[31:24] = imem_data;
                    default: ;
                endcase
                if (cnt_q == 3'd4) begin
                    state_d = S_VALID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    pc_d    = PCSrc ? (BranchAddress & ~64'h3) : (pc_q + 64'd4);
`ifdef FETCH_HALT_DETECT_EN
                    // HALT wins over any redirect and freezes the PC.
                    if (instr_q[31:21] == 11'h7FF) begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                    end
`endif
                end
            end

`ifdef FETCH_HALT_DETECT_EN
            S_HALTED: begin
                halted = 1'b1;
            end
`endif

            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign instruction = instr_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A byte-array memory model answers reads
// with one cycle of latency. The driver issues handshakes and, from a
// word-level reference model (PC arithmetic and little-endian word assembly),
// pushes the next expected (PC, instruction) and the four expected memory
// addresses into queues. An independent monitor pops and compares whenever
// the DUT raises inst_valid or strobes imem_rd.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] imem_addr;
    logic        imem_rd;
    logic [7:0]  imem_data = 8'h00;
    logic [31:0] instruction;
    logic [63:0] PC;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [63:0] BranchAddress = 64'h0;
    logic        halted;

    fetch_unit #(.PC_RESET(64'h0), .ADDR_W(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .PC            (PC),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .PCSrc         (PCSrc),
        .BranchAddress (BranchAddress),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous read, one cycle latency; garbage when idle.
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        imem_data <= imem_rd ? mem[imem_addr] : 8'($urandom);
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q [$];
    logic [11:0] addr_q [$];
    logic [63:0] cur_pc;
    logic [31:0] cur_instr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is four little-endian bytes from the wrapped
    // 12-bit byte address.
    function automatic logic [31:0] word_at(input logic [63:0] pc);
        int a;
        a = int'(pc[11:0]);
        return {mem[(a + 3) % 4096], mem[(a + 2) % 4096], mem[(a + 1) % 4096], mem[a]};
    endfunction

    function automatic bit is_halt(input logic [31:0] w);
`ifdef FETCH_HALT_DETECT_EN
        return w[31:21] == 11'h7FF;
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_fetch(input logic [63:0] pc);
        logic [11:0] a;
        cur_pc    = pc;
        cur_instr = word_at(pc);
        exp_q.push_back('{pc: pc, instr: cur_instr});
        a = pc[11:0];
        for (int k = 0; k < 4; k++) addr_q.push_back(a + 12'(k));
    endtask

    // Monitor: compares every presented instruction and every memory read.
    initial begin : monitor
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (inst_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got PC %h with nothing expected", PC);
                    end else begin
                        e = exp_q.pop_front();
                        check("valid_pc", PC, e.pc);
                        check("valid_instr", 64'(instruction), 64'(e.instr));
                    end
                end
                if (imem_rd) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got addr %h with nothing expected", imem_addr);
                    end else begin
                        check("imem_addr", 64'(imem_addr), 64'(addr_q.pop_front()));
                    end
                end else begin
                    check("idle_addr", 64'(imem_addr), 64'h0);
                end
                prev_v = inst_valid;
            end
        end
    end

    // Wait (bounded) for inst_valid; n counts negedges waited.
    task automatic wait_valid(input int exp_cycles, input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid after %0d cycles expected %0d", name, n, exp_cycles);
        end else begin
            check(name, 64'(n), 64'(exp_cycles));
        end
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            inst_ready    = 1'b0;
            PCSrc         = 1'b1;
            BranchAddress = {$urandom, $urandom};
            @(negedge clk);
            check("stall_valid", 64'(inst_valid), 64'h1);
            check("stall_rd", 64'(imem_rd), 64'h0);
            check("stall_pc", PC, cur_pc);
            check("stall_instr", 64'(instruction), 64'(cur_instr));
        end
    endtask

    // One-cycle ready pulse; the model computes the next fetch PC.
    task automatic ack(input bit src, input logic [63:0] ba);
        inst_ready    = 1'b1;
        PCSrc         = src;
        BranchAddress = ba;
        if (!is_halt(cur_instr)) expect_fetch(src ? (ba & ~64'h3) : (cur_pc + 64'd4));
        @(negedge clk);
        inst_ready    = 1'b0;
        PCSrc         = 1'($urandom_range(0, 1));
        BranchAddress = {$urandom, $urandom};
        check("one_handshake", 64'(inst_valid), 64'h0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [63:0] ba;
        int n;

        // Random program; bit 31 of every word is cleared so no stray HALT.
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            if (i % 4 == 3) mem[i][7] = 1'b0;
        end
        mem[0] = 8'h8B; mem[1] = 8'h02; mem[2] = 8'h1F; mem[3] = 8'h91;
        mem[12'h100] = 8'h00; mem[12'h101] = 8'h00;
        mem[12'h102] = 8'hE0; mem[12'h103] = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_pc", PC, 64'h0);
        check("rst_instr", 64'(instruction), 64'h0);
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_rd", 64'(imem_rd), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h0);
        check("rst_halted", 64'(halted), 64'h0);

        expect_fetch(64'h0);
        reset = 1'b0;
        wait_valid(6, "first_latency");

        // Sequential, with a 10-cycle stall carrying a live redirect.
        ack(1'b0, 64'h0);
        wait_valid(5, "seq_spacing");
        stall(10);
        ack(1'b0, 64'h0);
        wait_valid(5, "seq_spacing");

        // Branch with unaligned target, then wrap at the top of memory.
        ack(1'b1, 64'h2E);
        wait_valid(5, "branch_spacing");
        ack(1'b1, 64'hFFD);
        wait_valid(5, "branch_spacing");
        ack(1'b0, 64'h0);
        wait_valid(5, "wrap_spacing");

        // Random traffic; targets keep clear of the HALT word at 0x100.
        for (int i = 0; i < 20; i++) begin
            stall($urandom_range(0, 3));
            ba = {$urandom, $urandom};
            ba[11:0] = 12'($urandom_range(12'h200, 12'hFF0));
            ack(1'($urandom_range(0, 1)), ba);
            wait_valid(5, "rand_spacing");
        end

        // HALT word.
        ack(1'b1, 64'h102);
        wait_valid(5, "halt_spacing");
`ifdef FETCH_HALT_DETECT_EN
        ack(1'b1, 64'h48);
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", 64'(halted), 64'h1);
            check("halt_rd", 64'(imem_rd), 64'h0);
            check("halt_valid", 64'(inst_valid), 64'h0);
            check("halt_pc", PC, 64'h100);
            check("halt_instr", 64'(instruction), 64'hFFE00000);
            @(negedge clk);
        end
`else
        ack(1'b0, 64'h0);
        wait_valid(5, "nohalt_spacing");
        check("nohalt_halted", 64'(halted), 64'h0);
`endif

        // Reset, then reset again in the middle of the first fetch (cnt=2).
        #2 reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        check("rst2_halted", 64'(halted), 64'h0);
        expect_fetch(64'h0);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_rd && imem_addr == 12'h2) && n < 20);
        check("midfetch_reached", 64'(n < 20), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_pc", PC, 64'h0);
        check("midrst_instr", 64'(instruction), 64'h0);
        check("midrst_valid", 64'(inst_valid), 64'h0);
        check("midrst_rd", 64'(imem_rd), 64'h0);
        check("midrst_addr", 64'(imem_addr), 64'h0);
        check("midrst_halted", 64'(halted), 64'h0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        expect_fetch(64'h0);
        reset = 1'b0;
        wait_valid(6, "refetch_latency");

        @(negedge clk);
        check("exp_drained", 64'(exp_q.size()), 64'h0);
        check("addr_drained", 64'(addr_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
